id_operand_stage: RTL and testbench

//   Parametrised operand-resolution stage between decode and EX.

---
 rtl/id_operand_stage.sv | 108 ++++++++++
 tb/tb_id_operand_stage.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/id_operand_stage.sv
// Operand-resolution stage between decode and EX.
// Each source operand comes from the immediate, hard-wired r0, the youngest matching
// bypass stage, or the regfile. A matching bypass whose data is not ready yet raises an
// interlock stall. Resolved operands are registered into a one-entry ID/EX buffer.
module id_operand_stage #(
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned ADDR_W  = 5,
  parameter int unsigned NUM_SRC = 2,
  parameter int unsigned NUM_FWD = 2
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        flush,
  input  logic                        id_valid_i,
  output logic                        id_ready_o,
  input  logic [NUM_SRC-1:0]          src_read_i,
  input  logic [NUM_SRC*ADDR_W-1:0]   src_addr_i,
  input  logic [DATA_W-1:0]           imm_i,
  input  logic [NUM_SRC*DATA_W-1:0]   rf_data_i,
  input  logic [NUM_FWD-1:0]          fwd_we_i,
  input  logic [NUM_FWD*ADDR_W-1:0]   fwd_addr_i,
  input  logic [NUM_FWD-1:0]          fwd_rdy_i,
  input  logic [NUM_FWD*DATA_W-1:0]   fwd_data_i,
  output logic                        ex_valid_o,
  input  logic                        ex_ready_i,
  output logic [NUM_SRC*DATA_W-1:0]   opnd_o,
  output logic                        stall_req_o,
  output logic [15:0]                 stall_cnt_o
);

  typedef enum logic {StEmpty, StFull} buf_state_e;

  buf_state_e                state_q;
  logic [NUM_SRC*DATA_W-1:0] opnd_q;
  logic [15:0]               stall_cnt_q;

  logic [NUM_SRC*DATA_W-1:0] opnd_res;
  logic [NUM_SRC-1:0]        hazard;
  logic [ADDR_W-1:0]         addr;
  logic                      hit;
  logic                      accept;

  // Per-source operand selection; the first (youngest) matching bypass stage wins.
  always_comb begin
    opnd_res = '0;
    hazard   = '0;
    addr     = '0;
    hit      = 1'b0;
    for (int s = 0; s < NUM_SRC; s++) begin
      addr = src_addr_i[s*ADDR_W +: ADDR_W];
      hit  = 1'b0;
      if (!src_read_i[s]) begin
        opnd_res[s*DATA_W +: DATA_W] = imm_i;
      end else if (addr == '0) begin
        opnd_res[s*DATA_W +: DATA_W] = '0;
      end else begin
        opnd_res[s*DATA_W +: DATA_W] = rf_data_i[s*DATA_W +: DATA_W];
        for (int k = 0; k < NUM_FWD; k++) begin
          if (!hit && fwd_we_i[k] && (fwd_addr_i[k*ADDR_W +: ADDR_W] == addr)) begin
            hit = 1'b1;
            if (fwd_rdy_i[k]) begin
              opnd_res[s*DATA_W +: DATA_W] = fwd_data_i[k*DATA_W +: DATA_W];
            end else begin
              // Load still in flight: operand value is irrelevant, the stall blocks accept.
              hazard[s] = 1'b1;
            end
          end
        end
      end
    end
  end

  // Handshake and interlock decisions.
  always_comb begin
    stall_req_o = id_valid_i & (|hazard);
    id_ready_o  = ~stall_req_o & ((state_q == StEmpty) | ex_ready_i);
    accept      = id_valid_i & id_ready_o & ~flush;
  end

  // One-entry ID/EX buffer; flush dominates both accept and hold.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StEmpty;
      opnd_q  <= '0;
    end else if (flush) begin
      state_q <= StEmpty;
    end else if (accept) begin
      state_q <= StFull;
      opnd_q  <= opnd_res;
    end else if (ex_ready_i) begin
      state_q <= StEmpty;
    end
  end

  // Saturating interlock cycle counter, only cleared by reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt_q <= '0;
    end else if (stall_req_o && (stall_cnt_q != 16'hFFFF)) begin
      stall_cnt_q <= stall_cnt_q + 16'd1;
    end
  end

  assign ex_valid_o  = (state_q == StFull);
  assign opnd_o      = opnd_q;
  assign stall_cnt_o = stall_cnt_q;

endmodule

// File: tb/tb_id_operand_stage.sv
// Scoreboard bench for id_operand_stage: directed scenarios followed by random traffic.
module tb_id_operand_stage;

  localparam int DW = 32;
  localparam int AW = 5;
  localparam int NS = 2;
  localparam int NF = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic flush, id_valid_i, id_ready_o, ex_valid_o, ex_ready_i, stall_req_o;
  logic [NS-1:0]    src_read_i;
  logic [NS*AW-1:0] src_addr_i;
  logic [DW-1:0]    imm_i;
  logic [NS*DW-1:0] rf_data_i;
  logic [NF-1:0]    fwd_we_i, fwd_rdy_i;
  logic [NF*AW-1:0] fwd_addr_i;
  logic [NF*DW-1:0] fwd_data_i;
  logic [NS*DW-1:0] opnd_o;
  logic [15:0]      stall_cnt_o;

  // Stimulus held as per-source / per-stage arrays, packed onto the ports below.
  logic          t_read  [NS];
  logic [AW-1:0] t_addr  [NS];
  logic [DW-1:0] t_rf    [NS];
  logic          t_we    [NF];
  logic [AW-1:0] t_faddr [NF];
  logic          t_rdy   [NF];
  logic [DW-1:0] t_fdata [NF];

  always_comb begin
    for (int s = 0; s < NS; s++) begin
      src_read_i[s]            = t_read[s];
      src_addr_i[s*AW +: AW]   = t_addr[s];
      rf_data_i[s*DW +: DW]    = t_rf[s];
    end
    for (int k = 0; k < NF; k++) begin
      fwd_we_i[k]              = t_we[k];
      fwd_rdy_i[k]             = t_rdy[k];
      fwd_addr_i[k*AW +: AW]   = t_faddr[k];
      fwd_data_i[k*DW +: DW]   = t_fdata[k];
    end
  end

  id_operand_stage #(
    .DATA_W (DW),
    .ADDR_W (AW),
    .NUM_SRC(NS),
    .NUM_FWD(NF)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .flush      (flush),
    .id_valid_i (id_valid_i),
    .id_ready_o (id_ready_o),
    .src_read_i (src_read_i),
    .src_addr_i (src_addr_i),
    .imm_i      (imm_i),
    .rf_data_i  (rf_data_i),
    .fwd_we_i   (fwd_we_i),
    .fwd_addr_i (fwd_addr_i),
    .fwd_rdy_i  (fwd_rdy_i),
    .fwd_data_i (fwd_data_i),
    .ex_valid_o (ex_valid_o),
    .ex_ready_i (ex_ready_i),
    .opnd_o     (opnd_o),
    .stall_req_o(stall_req_o),
    .stall_cnt_o(stall_cnt_o)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  logic [NS*DW-1:0] sb [$];
  logic             mdl_full = 1'b0;
  int               mdl_cnt  = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference: immediate, r0, youngest matching producer, else regfile.
  task automatic ref_resolve(output logic [NS*DW-1:0] opnd, output logic any_hz);
    int hit;
    opnd   = '0;
    any_hz = 1'b0;
    for (int s = 0; s < NS; s++) begin
      if (!t_read[s]) begin
        opnd[s*DW +: DW] = imm_i;
      end else if (t_addr[s] == 0) begin
        opnd[s*DW +: DW] = '0;
      end else begin
        hit = -1;
        for (int k = NF - 1; k >= 0; k--)
          if (t_we[k] && t_faddr[k] == t_addr[s]) hit = k;
        if (hit < 0)             opnd[s*DW +: DW] = t_rf[s];
        else if (t_rdy[hit])     opnd[s*DW +: DW] = t_fdata[hit];
        else                     any_hz = 1'b1;
      end
    end
  endtask

  // Monitor: buffer occupancy and contents against the scoreboard head.
  always @(negedge clk) begin
    if (!rst) begin
      check("ex_valid", 64'(ex_valid_o), 64'(mdl_full));
      if (ex_valid_o) begin
        if (sb.size() == 0) begin
          check("sb_empty", 64'(1), 64'(0));
        end else begin
          check("opnd", 64'(opnd_o), 64'(sb[0]));
          if (ex_ready_i) void'(sb.pop_front());
        end
      end
    end
  end

  // One cycle: inputs already applied just after the previous rising edge.
  task automatic step();
    logic [NS*DW-1:0] exp_op;
    logic hz, stall, rdy, acc;
    @(negedge clk);
    #1;
    ref_resolve(exp_op, hz);
    stall = id_valid_i && hz;
    rdy   = !stall && (!mdl_full || ex_ready_i);
    acc   = id_valid_i && rdy && !flush;
    check("stall_req", 64'(stall_req_o), 64'(stall));
    check("id_ready", 64'(id_ready_o), 64'(rdy));
    if (stall && mdl_cnt < 65535) mdl_cnt++;
    if (flush) begin
      sb.delete();
      mdl_full = 1'b0;
    end else if (acc) begin
      sb.push_back(exp_op);
      mdl_full = 1'b1;
    end else if (ex_ready_i) begin
      mdl_full = 1'b0;
    end
    @(posedge clk);
    #1;
    check("stall_cnt", 64'(stall_cnt_o), 64'(mdl_cnt));
  endtask

  task automatic idle();
    flush = 1'b0; id_valid_i = 1'b0; ex_ready_i = 1'b1; imm_i = '0;
    for (int s = 0; s < NS; s++) begin
      t_read[s] = 1'b0; t_addr[s] = '0; t_rf[s] = '0;
    end
    for (int k = 0; k < NF; k++) begin
      t_we[k] = 1'b0; t_faddr[k] = '0; t_rdy[k] = 1'b1; t_fdata[k] = '0;
    end
  endtask

  int cnt0;

  initial begin
    idle();
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    check("rst_valid", 64'(ex_valid_o), 64'(0));
    check("rst_opnd", 64'(opnd_o), 64'(0));
    check("rst_cnt", 64'(stall_cnt_o), 64'(0));
    check("rst_ready", 64'(id_ready_o), 64'(1));
    check("rst_stall", 64'(stall_req_o), 64'(0));

    // 1: EX bypass beats MEM bypass and regfile.
    id_valid_i = 1'b1; t_read[0] = 1'b1; t_addr[0] = 5'd3; t_rf[0] = 32'h11;
    t_we[0] = 1'b1; t_faddr[0] = 5'd3; t_fdata[0] = 32'hAA;
    t_we[1] = 1'b1; t_faddr[1] = 5'd3; t_fdata[1] = 32'hBB;
    step();
    check("t1_opnd0", 64'(opnd_o[DW-1:0]), 64'(32'hAA));
    idle();
    step();

    // 2: load-use interlock for two cycles on source 1.
    cnt0 = mdl_cnt;
    id_valid_i = 1'b1; t_read[1] = 1'b1; t_addr[1] = 5'd5;
    t_we[0] = 1'b1; t_faddr[0] = 5'd5; t_rdy[0] = 1'b0;
    step();
    check("t2_stall", 64'(stall_req_o), 64'(1));
    step();
    check("t2_cnt", 64'(stall_cnt_o), 64'(cnt0 + 2));
    t_rdy[0] = 1'b1; t_fdata[0] = 32'h55;
    step();
    check("t2_valid", 64'(ex_valid_o), 64'(1));
    check("t2_opnd1", 64'(opnd_o[DW +: DW]), 64'(32'h55));
    idle();
    step();

    // 3: r0 ignores a pending producer; immediate operand.
    id_valid_i = 1'b1; t_read[0] = 1'b1; t_addr[0] = 5'd0;
    t_we[0] = 1'b1; t_faddr[0] = 5'd0; t_rdy[0] = 1'b0; t_fdata[0] = 32'hFF;
    imm_i = 32'h0000FFFF;
    step();
    check("t3_opnd", 64'(opnd_o), {32'h0000FFFF, 32'h0});
    idle();
    step();

    // 4: backpressure holds the buffer, then back-to-back replacement.
    id_valid_i = 1'b1; ex_ready_i = 1'b0; imm_i = 32'hA5A5_0001;
    step();
    imm_i = 32'h5A5A_0002;
    repeat (3) begin
      step();
      check("t4_hold", 64'(opnd_o), {2{32'hA5A5_0001}});
    end
    ex_ready_i = 1'b1;
    step();
    check("t4_next", 64'(opnd_o), {2{32'h5A5A_0002}});

    // 5: flush kills both the buffered and incoming instruction; async reset mid-hold.
    ex_ready_i = 1'b0; flush = 1'b1; imm_i = 32'hDEAD_0003;
    step();
    check("t5_flush", 64'(ex_valid_o), 64'(0));
    flush = 1'b0; imm_i = 32'h1234_0004;
    step();
    id_valid_i = 1'b0;
    step();
    #1 rst = 1'b1;
    #1;
    check("t5_rst_valid", 64'(ex_valid_o), 64'(0));
    check("t5_rst_opnd", 64'(opnd_o), 64'(0));
    check("t5_rst_cnt", 64'(stall_cnt_o), 64'(0));
    sb.delete();
    mdl_full = 1'b0;
    mdl_cnt  = 0;
    #1 rst = 1'b0;
    idle();
    step();

    // 6: long hazard saturates the stall counter.
    id_valid_i = 1'b1; t_read[0] = 1'b1; t_addr[0] = 5'd1;
    t_we[0] = 1'b1; t_faddr[0] = 5'd1; t_rdy[0] = 1'b0;
    repeat (70000) @(posedge clk);
    #1;
    mdl_cnt = (mdl_cnt + 70000 > 65535) ? 65535 : mdl_cnt + 70000;
    check("t6_sat", 64'(stall_cnt_o), 64'(16'hFFFF));
    step();
    check("t6_sat_hold", 64'(stall_cnt_o), 64'(16'hFFFF));
    idle();
    step();

    // Random traffic over a small address space to provoke bypass matches.
    for (int i = 0; i < 400; i++) begin
      id_valid_i = ($urandom_range(0, 3) != 0);
      ex_ready_i = ($urandom_range(0, 9) < 7);
      flush      = ($urandom_range(0, 15) == 0);
      imm_i      = $urandom;
      for (int s = 0; s < NS; s++) begin
        t_read[s] = ($urandom_range(0, 4) != 0);
        t_addr[s] = AW'($urandom_range(0, 3));
        t_rf[s]   = $urandom;
      end
      for (int k = 0; k < NF; k++) begin
        t_we[k]    = $urandom_range(0, 1);
        t_faddr[k] = AW'($urandom_range(0, 3));
        t_rdy[k]   = ($urandom_range(0, 3) != 0);
        t_fdata[k] = $urandom;
      end
      step();
    end
    idle();
    step();
    step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
